// File: rtl/seg_display_ctrl_pkg.sv
// Shared types, constants and the segment decoder for the 4-digit display controller.
package seg_pkg;

    // Control FSM states: wait for a request, convert it, load the display register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Digit code: 0-15 are hex digits, the two codes above them are non-numeric glyphs.
    typedef logic [4:0] digit_t;

    localparam digit_t DIG_BLANK = 5'd16;
    localparam digit_t DIG_DASH  = 5'd17;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg_decode(input digit_t d);
        logic [6:0] s;
        case (d)
            5'd0:     s = 7'b1000000;
            5'd1:     s = 7'b1111001;
            5'd2:     s = 7'b0100100;
            5'd3:     s = 7'b0110000;
            5'd4:     s = 7'b0011001;
            5'd5:     s = 7'b0010010;
            5'd6:     s = 7'b0000010;
            5'd7:     s = 7'b1011000;
            5'd8:     s = 7'b0000000;
            5'd9:     s = 7'b0010000;
            5'd10:    s = 7'b0001000;
            5'd11:    s = 7'b0000011;
            5'd12:    s = 7'b1000110;
            5'd13:    s = 7'b0100001;
            5'd14:    s = 7'b0000110;
            5'd15:    s = 7'b0001110;
            DIG_DASH: s = SEG_DASH;
            default:  s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// Two-requester valid/ready bus feeding values to the display controller.
interface seg_display_ctrl_if;
    logic [1:0]  req_valid;
    logic [15:0] req_data0;
    logic [15:0] req_data1;
    logic [1:0]  req_ready;

    // Requester side drives values, controller side answers with ready.
    modport master (output req_valid, req_data0, req_data1, input req_ready);
    modport slave  (input req_valid, req_data0, req_data1, output req_ready);
endinterface

// File: rtl/seg_display_ctrl_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, 16 cycles per value.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [15:0] bcd,
    output logic        ovf
);

    logic        run_q;
    logic [3:0]  cnt_q;
    logic [15:0] sr_q;
    logic [19:0] bcd_q;
    logic [19:0] bcd_adj;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_q);

    // Load on start, then shift one binary bit into the BCD register per cycle.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= 4'd0;
            sr_q  <= 16'd0;
            bcd_q <= 20'd0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= 4'd0;
            sr_q  <= bin;
            bcd_q <= 20'd0;
        end else if (run_q) begin
            bcd_q <= {bcd_adj[18:0], sr_q[15]};
            sr_q  <= {sr_q[14:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_q <= 1'b0;
            end
        end
    end

    // done is high in the cycle whose closing edge performs the last iteration.
    assign done = run_q && (cnt_q == 4'd15);
    assign bcd  = bcd_q[15:0];
    assign ovf  = |bcd_q[19:16];

endmodule

// File: rtl/seg_display_ctrl.sv
// Round-robin intake of two requesters, BCD conversion and multiplexed 7-segment scan.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    seg_display_ctrl_if.slave  req,
    output logic               busy,
    output logic               src,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    state_t          state_q, state_d;
    logic            last_q;
    logic            gnt;
    logic            conv_start;
    logic            disp_load;
    logic            conv_done;
    logic [15:0]     conv_bcd;
    logic            conv_ovf;
    digit_t [3:0]    disp_q, disp_d;
    logic [PW-1:0]   presc_q;
    logic [1:0]      idx_q;

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (gnt ? req.req_data1 : req.req_data0),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .ovf     (conv_ovf)
    );

    // Round-robin pick: on a tie, take the requester after the last one granted.
    always_comb begin
        gnt = req.req_valid[1];
        if (req.req_valid == 2'b11) begin
            gnt = ~last_q;
        end
    end

    // Next-state and handshake decode for the control FSM.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        req.req_ready = 2'b00;
        conv_start    = 1'b0;
        disp_load     = 1'b0;
        case (state_q)
            IDLE: begin
                req.req_ready = gnt ? {req.req_valid[1], 1'b0} : {1'b0, req.req_valid[0]};
                if (req.req_valid[gnt]) begin
                    conv_start = 1'b1;
                    state_d    = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_load = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register and round-robin pointer (pointer also records the granted source).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (conv_start) begin
                last_q <= gnt;
            end
        end
    end

    assign busy = (state_q == CONV);

    // Build the next display set: dashes on overflow, else digits with optional leading-zero blanking.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            disp_d[i] = {1'b0, conv_bcd[4*i +: 4]};
        end
        if (conv_ovf || (conv_bcd[15:12] > 4'd9)) begin
            disp_d = {4{DIG_DASH}};
        end else if (BLANK_LZ && (conv_bcd[15:12] == 4'd0)) begin
            disp_d[3] = DIG_BLANK;
            if (conv_bcd[11:8] == 4'd0) begin
                disp_d[2] = DIG_BLANK;
                if (conv_bcd[7:4] == 4'd0) begin
                    disp_d[1] = DIG_BLANK;
                end
            end
        end
    end

    // Front display buffer: loaded whole in LOAD so the scan never sees a half-built value.
    // NOTE: this small register set is reset so the panel is blank, not random, after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= {4{DIG_BLANK}};
            src    <= 1'b0;
        end else if (disp_load) begin
            disp_q <= disp_d;
            src    <= last_q;
        end
    end

    // Free-running prescaler; the digit index advances on its wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Registered pin drivers: one active-low anode and its decoded segment pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= seg_decode(disp_q[idx_q]);
            an  <= ~(4'b0001 << idx_q);
        end
    end

endmodule
